mul_share_ctrl: RTL and testbench

Round-robin controller that shares one sequential 8x8 signed Booth multiplier among NUM_REQ requesters. It arbitrates between requesters and captures the granted requester's operands. It then drives the multiplier's start/ready handshake, returns the 16-bit product tagged with the requester ID, and includes a watchdog for a hung multiplier.

---
 rtl/mul_share_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mul_share_ctrl.sv | 561 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// mul_share_ctrl
//
// Shares one sequential 8x8 signed multiplier among NUM_REQ requesters.
// A round-robin arbiter picks a requester while the multiplier is idle,
// captures that requester's operands, drives the start/ready handshake,
// and returns the 16-bit product tagged with the requester ID. A watchdog
// turns a hung multiplier into an error response instead of a lockup.
//
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   req_valid[NUM_REQ]    per-requester request level, held until granted
//   req_m, req_r          packed 8-bit operands, requester i at [8i+7:8i]
//   req_grant[NUM_REQ]    one-hot, one-cycle pulse: operands captured
//   resp_valid            one-cycle pulse: resp_id/resp_data/resp_err valid
//   resp_id               requester that was served
//   resp_data             signed product, 0 when resp_err is set
//   resp_err              watchdog expired for this response
//   busy                  high whenever the controller is not idle
//   mul_start             start strobe to the multiplier
//   mul_m, mul_r          registered operands to the multiplier
//   mul_ready             multiplier idle flag
//   mul_ans               multiplier product, stable while mul_ready is high
// -----------------------------------------------------------------------------
module mul_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 31
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_m,
    input  logic [8*NUM_REQ-1:0]   req_r,
    output logic [NUM_REQ-1:0]     req_grant,
    output logic                   resp_valid,
    output logic [ID_W-1:0]        resp_id,
    output logic [15:0]            resp_data,
    output logic                   resp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [7:0]             mul_m,
    output logic [7:0]             mul_r,
    input  logic                   mul_ready,
    input  logic [15:0]            mul_ans
);

    localparam int                TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     TIMER_MAX = TW'(TIMEOUT);
    localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        RESP
    } state_t;

    state_t              state, state_d;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
    logic [ID_W-1:0]     sel, sel_d;
    logic [TW-1:0]       timer, timer_d;

    logic [NUM_REQ-1:0]  req_grant_d;
    logic                resp_valid_d;
    logic [ID_W-1:0]     resp_id_d;
    logic [15:0]         resp_data_d;
    logic                resp_err_d;
    logic                busy_d;
    logic                mul_start_d;
    logic [7:0]          mul_m_d;
    logic [7:0]          mul_r_d;

    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic [ID_W-1:0]     arb_cand;
    int                  arb_sum;

    // Round-robin search: the first asserted request at or above the
    // pointer wins, wrapping past NUM_REQ-1 back to 0. The wrap is done
    // in integer arithmetic so NUM_REQ need not be a power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        arb_cand   = '0;
        arb_sum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_sum = int'(rr_ptr) + k;
            if (arb_sum >= NUM_REQ) begin
                arb_sum = arb_sum - NUM_REQ;
            end
            arb_cand = ID_W'(arb_sum);
            if (!pick_found && req_valid[arb_cand]) begin
                pick_found = 1'b1;
                pick_idx   = arb_cand;
            end
        end
    end

    // Next-state and next-output logic. Every output is registered, so
    // each *_d value is what the output shows during the next state.
    // Watchdog expiry is tested before mul_ready so that a same-cycle
    // ready transition loses to the timeout.
    always_comb begin
        state_d      = state;
        rr_ptr_d     = rr_ptr;
        sel_d        = sel;
        timer_d      = timer;
        req_grant_d  = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id;
        resp_data_d  = resp_data;
        resp_err_d   = resp_err;
        mul_start_d  = 1'b0;
        mul_m_d      = mul_m;
        mul_r_d      = mul_r;

        case (state)
            IDLE: begin
                // A multiplier that is still busy (e.g. after a reset of
                // the controller alone) must finish before a new grant.
                if (pick_found && mul_ready) begin
                    sel_d                 = pick_idx;
                    mul_m_d               = req_m[{pick_idx, 3'b000} +: 8];
                    mul_r_d               = req_r[{pick_idx, 3'b000} +: 8];
                    req_grant_d[pick_idx] = 1'b1;
                    mul_start_d           = 1'b1;
                    state_d               = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK, WAIT_DONE: begin
                if (timer == TIMER_MAX) begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = sel;
                    resp_data_d  = 16'h0000;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else begin
                    timer_d = timer + TW'(1);
                    if (state == WAIT_ACK) begin
                        if (!mul_ready) begin
                            state_d = WAIT_DONE;
                        end
                    end else if (mul_ready) begin
                        resp_valid_d = 1'b1;
                        resp_id_d    = sel;
                        resp_data_d  = mul_ans;
                        resp_err_d   = 1'b0;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                rr_ptr_d = (sel == LAST_ID) ? '0 : sel + ID_W'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            sel        <= '0;
            timer      <= '0;
            req_grant  <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= 16'h0000;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            mul_start  <= 1'b0;
            mul_m      <= 8'h00;
            mul_r      <= 8'h00;
        end else begin
            state      <= state_d;
            rr_ptr     <= rr_ptr_d;
            sel        <= sel_d;
            timer      <= timer_d;
            req_grant  <= req_grant_d;
            resp_valid <= resp_valid_d;
            resp_id    <= resp_id_d;
            resp_data  <= resp_data_d;
            resp_err   <= resp_err_d;
            busy       <= busy_d;
            mul_start  <= mul_start_d;
            mul_m      <= mul_m_d;
            mul_r      <= mul_r_d;
        end
    end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mul_share_ctrl
//
// Bench for mul_share_ctrl with a behavioural sequential multiplier model
// (9 cycles busy after taking start, optional ready-stuck-high mode).
// A monitor pushes the expected response for every grant it sees onto a
// scoreboard queue and the observed responses onto a second queue; the
// scenario tasks pop and compare them.
// -----------------------------------------------------------------------------
module tb_mul_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 31;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_m;
    logic [8*NUM_REQ-1:0] req_r;
    logic [NUM_REQ-1:0]   req_grant;
    logic                 resp_valid;
    logic [ID_W-1:0]      resp_id;
    logic [15:0]          resp_data;
    logic                 resp_err;
    logic                 busy;
    logic                 mul_start;
    logic [7:0]           mul_m;
    logic [7:0]           mul_r;
    logic                 mul_ready;
    logic [15:0]          mul_ans;

    int checks = 0;
    int errors = 0;

    mul_share_ctrl #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_m      (req_m),
        .req_r      (req_r),
        .req_grant  (req_grant),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_m      (mul_m),
        .mul_r      (mul_r),
        .mul_ready  (mul_ready),
        .mul_ans    (mul_ans)
    );

    always #5 clk = ~clk;

    // Signed 8x8 product, low 16 bits of the sign-extended multiplication.
    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = {{8{a[7]}}, a};
        eb = {{8{b[7]}}, b};
        return ea * eb;
    endfunction

    // Multiplier model: takes start while ready, drops ready on that edge,
    // raises it 9 edges later with the product. It is not tied to rst so
    // it keeps running through a controller-only reset.
    logic        mdl_ready = 1'b1;
    logic [15:0] mdl_ans   = 16'h0000;
    logic [15:0] mdl_prod  = 16'h0000;
    int          mdl_cnt   = 0;
    bit          stuck     = 1'b0;

    assign mul_ready = mdl_ready;
    assign mul_ans   = mdl_ans;

    always @(posedge clk) begin
        if (stuck) begin
            mdl_ready <= 1'b1;
        end else if (mdl_ready && mul_start) begin
            mdl_ready <= 1'b0;
            mdl_cnt   <= 8;
            mdl_prod  <= smul(mul_m, mul_r);
            mdl_ans   <= 16'hDEAD;
        end else if (!mdl_ready) begin
            if (mdl_cnt == 0) begin
                mdl_ready <= 1'b1;
                mdl_ans   <= mdl_prod;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [15:0]     data;
        logic            err;
    } resp_t;

    resp_t exp_q[$];
    resp_t obs_q[$];
    int    grant_log[$];
    int    start_cnt   = 0;
    int    multihot    = 0;
    int    overlap     = 0;
    bit    outstanding = 1'b0;

    // Monitor: on each grant, compute the expected product from the
    // operands the bench is driving; record every response observed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 1'b0;
            end else begin
                if (mul_start) start_cnt++;
                if ($countones(req_grant) > 1) multihot++;
                if (req_grant != '0) begin
                    if (outstanding) overlap++;
                    outstanding = 1'b1;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (req_grant[i]) begin
                            grant_log.push_back(i);
                            exp_q.push_back('{id: ID_W'(i),
                                              data: smul(req_m[8*i +: 8], req_r[8*i +: 8]),
                                              err: 1'b0});
                        end
                    end
                end
                if (resp_valid) begin
                    outstanding = 1'b0;
                    obs_q.push_back('{id: resp_id, data: resp_data, err: resp_err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    // Waits until n responses have been observed; returns ok=0 if the
    // cycle budget runs out first.
    task automatic wait_obs(input int n, input int budget, output bit ok);
        int c;
        c  = 0;
        ok = 1'b1;
        while (obs_q.size() < n) begin
            @(negedge clk);
            #1;
            c++;
            if (c > budget) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        grant_log.delete();
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        clear_sb();
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_m     = '0;
        req_r     = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_grant, resp_valid, busy, mul_start} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {req_grant, resp_valid, busy, mul_start});
        end
        checks++;
        if ({resp_id, resp_data, resp_err} !== 19'b0) begin
            errors++;
            $display("[TB] FAIL reset_resp: got %h expected 0", {resp_id, resp_data, resp_err});
        end
        checks++;
        if ({mul_m, mul_r} !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_operands: got %h expected 0000", {mul_m, mul_r});
        end
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        int    c;
        int    lat;
        int    s0;
        bit    ok;
        resp_t o;
        resp_t e;
        s0 = start_cnt;
        #1;
        req_m[7:0] = 8'd3;
        req_r[7:0] = 8'd5;
        req_valid  = 4'b0001;
        c = 0;
        while (req_grant == '0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (req_grant !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL basic_grant: got %b expected 0001", req_grant);
        end
        #1 req_valid = '0;
        @(negedge clk);
        checks++;
        if (req_grant !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL basic_grant_pulse: got %b expected 0000", req_grant);
        end
        lat = 1;
        while (!resp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("[TB] FAIL basic_latency: got %0d expected 11", lat);
        end
        wait_obs(1, 5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL basic_resp_timeout: got %0d responses expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== resp_t'({2'd0, 16'h000F, 1'b0})) begin
                errors++;
                $display("[TB] FAIL basic_resp: got id %0d data %h err %b expected id 0 data 000f err 0",
                         o.id, o.data, o.err);
            end
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL basic_scoreboard: got %h expected %h", o, e);
            end
        end
        checks++;
        if (start_cnt - s0 !== 1) begin
            errors++;
            $display("[TB] FAIL basic_start_pulses: got %0d expected 1", start_cnt - s0);
        end
        repeat (2) @(negedge clk);
        clear_sb();
    endtask

    task automatic test_signed();
        bit    ok;
        resp_t o;
        resp_t e;
        #1;
        req_m[15:8] = 8'hF9;
        req_r[15:8] = 8'h06;
        req_valid   = 4'b0010;
        wait_obs(1, 60, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL signed_timeout: got %0d responses expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== resp_t'({2'd1, 16'hFFD6, 1'b0})) begin
                errors++;
                $display("[TB] FAIL signed_resp: got id %0d data %h err %b expected id 1 data ffd6 err 0",
                         o.id, o.data, o.err);
            end
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL signed_scoreboard: got %h expected %h", o, e);
            end
        end
        repeat (2) @(negedge clk);
        clear_sb();
    endtask

    task automatic test_all_four();
        bit    ok;
        resp_t o;
        resp_t e;
        int    exp_order[5] = '{0, 1, 2, 3, 0};
        pulse_reset();
        req_m     = {8'h05, 8'hF0, 8'h80, 8'h7F};
        req_r     = {8'hFB, 8'h0C, 8'h80, 8'h7F};
        req_valid = 4'b1111;
        wait_obs(5, 120, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL all4_timeout: got %0d responses expected 5", obs_q.size());
        end
        checks++;
        if (grant_log.size() !== 5) begin
            errors++;
            $display("[TB] FAIL all4_grant_count: got %0d expected 5", grant_log.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (grant_log[k] !== exp_order[k]) begin
                    errors++;
                    $display("[TB] FAIL all4_order[%0d]: got %0d expected %0d", k, grant_log[k], exp_order[k]);
                end
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL all4_resp: got %h expected %h", o, e);
            end
        end
        checks++;
        if (multihot + overlap !== 0) begin
            errors++;
            $display("[TB] FAIL all4_exclusive: got multihot %0d overlap %0d expected 0 0", multihot, overlap);
        end
        repeat (3) @(negedge clk);
        clear_sb();
    endtask

    task automatic test_alternate();
        bit    ok;
        resp_t o;
        resp_t e;
        int    exp_order[4] = '{0, 2, 0, 2};
        pulse_reset();
        req_m     = {8'h00, 8'h80, 8'h00, 8'd11};
        req_r     = {8'h00, 8'h80, 8'h00, 8'hFE};
        req_valid = 4'b0101;
        wait_obs(4, 100, ok);
        req_valid = '0;
        checks++;
        if (!ok || grant_log.size() !== 4) begin
            errors++;
            $display("[TB] FAIL alt_count: got %0d grants expected 4", grant_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (grant_log[k] !== exp_order[k]) begin
                    errors++;
                    $display("[TB] FAIL alt_order[%0d]: got %0d expected %0d", k, grant_log[k], exp_order[k]);
                end
            end
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL alt_resp: got %h expected %h", o, e);
            end
        end
        repeat (3) @(negedge clk);
        clear_sb();
    endtask

    task automatic test_watchdog();
        int    c;
        int    lat;
        bit    ok;
        resp_t o;
        stuck = 1'b1;
        #1;
        req_m[15:8] = 8'd4;
        req_r[15:8] = 8'd4;
        req_valid   = 4'b0010;
        c = 0;
        while (req_grant == '0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        #1 req_valid = '0;
        lat = 0;
        while (!resp_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("[TB] FAIL wd_latency: got %0d expected 33", lat);
        end
        wait_obs(1, 5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL wd_timeout: got %0d responses expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== resp_t'({2'd1, 16'h0000, 1'b1})) begin
                errors++;
                $display("[TB] FAIL wd_resp: got id %0d data %h err %b expected id 1 data 0000 err 1",
                         o.id, o.data, o.err);
            end
        end
        repeat (2) @(negedge clk);
        clear_sb();
        stuck = 1'b0;
        #1;
        req_m[23:16] = 8'hFF;
        req_r[23:16] = 8'hFF;
        req_valid    = 4'b0100;
        wait_obs(1, 60, ok);
        req_valid = '0;
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL wd_recover_timeout: got %0d responses expected 1", obs_q.size());
        end else begin
            o = obs_q.pop_front();
            checks++;
            if (o !== resp_t'({2'd2, 16'h0001, 1'b0})) begin
                errors++;
                $display("[TB] FAIL wd_recover_resp: got id %0d data %h err %b expected id 2 data 0001 err 0",
                         o.id, o.data, o.err);
            end
        end
        repeat (2) @(negedge clk);
        clear_sb();
    endtask

    task automatic test_reset_mid();
        int    c;
        int    early;
        bit    ok;
        resp_t o;
        resp_t e;
        int    exp_order[2] = '{1, 3};
        #1;
        req_m[31:24] = 8'd10;
        req_r[31:24] = 8'hFD;
        req_valid    = 4'b1000;
        c = 0;
        while (req_grant == '0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        repeat (5) @(negedge clk);
        // Controller is now in WAIT_DONE with the multiplier mid-operation.
        #1 rst = 1'b1;
        req_m[15:8] = 8'h0C;
        req_r[15:8] = 8'h0D;
        req_valid   = 4'b1010;
        #1;
        checks++;
        if ({req_grant, resp_valid, busy, mul_start, resp_err} !== 8'b0 ||
            {resp_id, resp_data, mul_m, mul_r} !== 34'b0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got %b %h expected all 0",
                     {req_grant, resp_valid, busy, mul_start, resp_err}, {resp_id, resp_data, mul_m, mul_r});
        end
        clear_sb();
        @(negedge clk);
        #1 rst = 1'b0;
        early = 0;
        c = 0;
        while (!mul_ready && c < 30) begin
            @(negedge clk);
            c++;
            if (req_grant != '0 && !mul_ready) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_grant_while_busy: got %0d grants expected 0", early);
        end
        // Pointer restarts at 0, so requester 1 wins over requester 3.
        wait_obs(1, 60, ok);
        req_valid[1] = 1'b0;
        wait_obs(2, 60, ok);
        req_valid = '0;
        checks++;
        if (!ok || grant_log.size() !== 2) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d grants expected 2", grant_log.size());
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (grant_log[k] !== exp_order[k]) begin
                    errors++;
                    $display("[TB] FAIL midreset_order[%0d]: got %0d expected %0d", k, grant_log[k], exp_order[k]);
                end
            end
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== resp_t'({2'd1, 16'h009C, 1'b0}) || o !== e) begin
                errors++;
                $display("[TB] FAIL midreset_resp1: got %h expected %h", o, resp_t'({2'd1, 16'h009C, 1'b0}));
            end
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o !== resp_t'({2'd3, 16'hFFE2, 1'b0}) || o !== e) begin
                errors++;
                $display("[TB] FAIL midreset_resp3: got %h expected %h", o, resp_t'({2'd3, 16'hFFE2, 1'b0}));
            end
        end
        repeat (3) @(negedge clk);
        clear_sb();
    endtask

    initial begin
        $display("[TB] mul_share_ctrl bench start");
        test_reset();
        test_basic();
        test_signed();
        test_all_four();
        test_alternate();
        test_watchdog();
        test_reset_mid();
        checks++;
        if (multihot !== 0) begin
            errors++;
            $display("[TB] FAIL final_multihot: got %0d expected 0", multihot);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
